// File: rtl/aes_cipher.sv
// AES-128 encryption core, one round per clock.
// Accepts a plaintext in S_IDLE, runs ten rounds in S_ROUND and holds the
// ciphertext in S_DONE until the downstream handshake completes.
module aes_cipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] plaintext_i,
  input  logic [127:0] round_key_i [0:10],
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] ciphertext_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {x, 3'b000};
    return SBOX[11'd2047 - idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes a0..a3 from MSB; matrix rows {2,3,1,1} rotated.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  state_t         state;
  logic [3:0]     round_idx;
  logic [127:0]   state_reg;
  logic [127:0]   sub_out;
  logic [127:0]   shift_out;
  logic [127:0]   mix_out;
  logic [127:0]   round_key;

  // SubBytes: four 32-bit sub_word lanes, one per state column.
  for (genvar w = 0; w < 4; w++) begin : g_sub_word
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign sub_out[127-32*w-8*b -: 8] = sbox(state_reg[127-32*w-8*b -: 8]);
    end
  end

  // ShiftRows: row r of column c takes row r of column (c + r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign shift_out[127-8*(4*c+r) -: 8] = sub_out[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix_out[127-32*c -: 32] = mix_column(shift_out[127-32*c -: 32]);
  end

  // Round key select; unreachable indices never reach the state register.
  always_comb begin
    round_key = '0;
    if (round_idx <= 4'd10) round_key = round_key_i[round_idx];
  end

  assign ciphertext_o = state_reg;

  // Control FSM with registered handshake outputs and the round datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      round_idx <= 4'd1;
      state_reg <= '0;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            state_reg <= plaintext_i ^ round_key_i[0];
            round_idx <= 4'd1;
            state     <= S_ROUND;
            ready_o   <= 1'b0;
          end
        end
        S_ROUND: begin
          if (round_idx >= 4'd1 && round_idx <= 4'd9) begin
            state_reg <= mix_out ^ round_key;
            round_idx <= round_idx + 4'd1;
          end else if (round_idx == 4'd10) begin
            state_reg <= shift_out ^ round_key;
            round_idx <= 4'd1;
            state     <= S_DONE;
            valid_o   <= 1'b1;
          end else begin
            // Corrupted counter: abandon the block silently.
            round_idx <= 4'd1;
            state     <= S_IDLE;
            ready_o   <= 1'b1;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            state   <= S_IDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher.sv
// Directed-vector bench for aes_cipher: known-answer tests, latency,
// backpressure, back-to-back handshake, mid-run reset and input disturbance.
module tb_aes_cipher;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] plaintext_i;
  logic [127:0] rk [0:10];
  logic         valid_o;
  logic         ready_i;
  logic [127:0] ciphertext_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [2047:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           bp;
    bit           disturb;
  } vec_t;

  vec_t vecs [5];

  aes_cipher dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .plaintext_i  (plaintext_i),
    .round_key_i  (rk),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .ciphertext_o (ciphertext_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tb_sb(input logic [7:0] x);
    logic [10:0] idx;
    idx = {x, 3'b000};
    return TB_SBOX[11'd2047 - idx -: 8];
  endfunction

  // FIPS-197 key schedule, written into the round key bus.
  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sb(t[31:24]), tb_sb(t[23:16]), tb_sb(t[15:8]), tb_sb(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One full transaction starting from S_IDLE with ready_i low until done.
  task automatic run_block(input vec_t v);
    int lat;
    logic [127:0] held;
    expand_key(v.key);
    plaintext_i = v.pt;
    ready_i = 1'b0;
    valid_i = 1'b1;
    check({v.name, " ready before accept"}, 128'(ready_o), 128'd1);
    step();
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 30) begin
      if (v.disturb) begin
        valid_i = lat[0];
        plaintext_i = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      lat++;
    end
    valid_i = 1'b0;
    check({v.name, " latency"}, 128'(lat), 128'd11);
    check({v.name, " ciphertext"}, ciphertext_o, v.ct);
    check({v.name, " ready in done"}, 128'(ready_o), 128'd0);
    held = ciphertext_o;
    for (int k = 0; k < v.bp; k++) begin
      step();
      check({v.name, " stall valid/ready"}, 128'({valid_o, ready_o}), 128'b10);
      check({v.name, " stall ciphertext"}, ciphertext_o, held);
    end
    ready_i = 1'b1;
    step();
    check({v.name, " handshake to idle"}, 128'({valid_o, ready_o}), 128'b01);
    ready_i = 1'b0;
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    int vcount;

    vecs[0] = '{"app_b",   KEY_B, PT_B, CT_B, 0, 1'b0};
    vecs[1] = '{"app_c1",  KEY_C, PT_C, CT_C, 5, 1'b0};
    vecs[2] = '{"zero",    128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2, 1'b0};
    vecs[3] = '{"gfsbox",  128'h0, 128'hf34481ec3cc627bacd5dc3fb08f273e6,
                128'h0336763e966d92595a567cc9ce537f5e, 0, 1'b0};
    vecs[4] = '{"disturb", KEY_B, PT_B, CT_B, 1, 1'b1};

    rst = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    plaintext_i = '0;
    for (int r = 0; r < 11; r++) rk[r] = '0;
    #1;
    check("reset ready/valid", 128'({ready_o, valid_o}), 128'b10);
    check("reset ciphertext", ciphertext_o, 128'h0);
    step();
    step();
    rst = 1'b0;
    step();
    check("idle after reset", 128'({ready_o, valid_o}), 128'b10);

    for (int i = 0; i < 5; i++) run_block(vecs[i]);

    // Back-to-back blocks with valid_i and ready_i held high.
    expand_key(KEY_B);
    plaintext_i = PT_B;
    valid_i = 1'b1;
    ready_i = 1'b1;
    n = 0;
    while (!ready_o && n < 30) begin step(); n++; end
    t1 = cyc;
    step();
    n = 0;
    while (!valid_o && n < 30) begin step(); n++; end
    check("b2b first ciphertext", ciphertext_o, CT_B);
    expand_key(KEY_C);
    plaintext_i = PT_C;
    n = 0;
    while (!ready_o && n < 30) begin step(); n++; end
    t2 = cyc;
    check("b2b accept spacing", 128'(t2 - t1), 128'd12);
    step();
    n = 0;
    while (!valid_o && n < 30) begin step(); n++; end
    valid_i = 1'b0;
    check("b2b second ciphertext", ciphertext_o, CT_C);
    step();
    check("b2b back to idle", 128'({ready_o, valid_o}), 128'b10);
    ready_i = 1'b0;

    // Reset pulsed in the middle of a block.
    expand_key(KEY_B);
    plaintext_i = PT_B;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    check("mid-run reset ready/valid", 128'({ready_o, valid_o}), 128'b10);
    check("mid-run reset ciphertext", ciphertext_o, 128'h0);
    step();
    rst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 14; k++) begin
      if (valid_o) vcount++;
      step();
    end
    check("no valid after abort", 128'(vcount), 128'd0);
    run_block(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_cipher.md
AES_CIPHER -- requirements
Module: aes_cipher

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 (10 rounds, 128-bit block).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 valid_i  input  1  plaintext_i valid; request to start one encryption.
REQ-005 ready_o  output  1  block idle, can accept a plaintext.
REQ-006 plaintext_i  input  128  plaintext block; bits[127:120] = byte 0 (FIPS-197 input order).
REQ-007 round_key_i  input  128 x 11 (unpacked [0:10])  expanded round keys, same byte order as plaintext_i.
REQ-008 valid_o  output  1  ciphertext_o valid.
REQ-009 ready_i  input  1  downstream accepts ciphertext_o.
REQ-010 ciphertext_o  output  128  encrypted block, same byte order.

Function
REQ-011 State array: column-major; column c = bits[127-32c -: 32]; row r of column c = byte r within that word, counted from the MSB.
REQ-012 FSM states: S_IDLE, S_ROUND, S_DONE; 2-bit encoding; any undefined encoding returns to S_IDLE.
REQ-013 S_IDLE: ready_o=1; on valid_i=1 (accept) -> state_reg <= plaintext_i ^ round_key_i[0], round_idx <= 1, go to S_ROUND.
REQ-014 S_IDLE with valid_i=0: no register change; plaintext_i ignored.
REQ-015 S_ROUND, round_idx 1..9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ round_key_i[round_idx]; round_idx += 1.
REQ-016 S_ROUND, round_idx 10: state_reg <= ShiftRows(SubBytes(state_reg)) ^ round_key_i[10]; go to S_DONE; round_idx <= 1.
REQ-017 SubBytes uses four instances of the existing sub_word S-box block; MixColumns uses xtime in GF(2^8) with modulus 0x11b.
REQ-018 One round per clock; no stall inside S_ROUND; ready_i and valid_i are ignored in S_ROUND.
REQ-019 Latency: valid_o first asserted 11 clocks after the accepting edge; minimum initiation interval 12 clocks (accept, 10 rounds, 1 DONE cycle with ready_i=1).
REQ-020 S_DONE: valid_o=1 and ciphertext_o=state_reg, both held stable until ready_i=1; on valid_o&ready_i -> S_IDLE.
REQ-021 ready_o=1 only in S_IDLE; valid_o=1 only in S_DONE; ready_o and valid_o are never both 1.
REQ-022 ciphertext_o is driven from state_reg in every state; it is meaningful only while valid_o=1.
REQ-023 round_key_i is not latched; the integrating top holds round_key_i stable from the accepting edge through the last S_ROUND cycle.
REQ-024 round_idx is a 4-bit counter; values 0 and 11..15 are unreachable. If one occurs in S_ROUND, the block goes to S_IDLE without asserting valid_o.
REQ-025 No back-to-back accept: a valid_i held high through S_DONE is accepted only after the block returns to S_IDLE.

Reset
REQ-026 rst=1 (asynchronous) -> state S_IDLE, round_idx=1, state_reg=0; hence ready_o=1, valid_o=0, ciphertext_o=0.
REQ-027 Reset asserted mid-encryption (S_ROUND or S_DONE) aborts the operation. No valid_o pulse for the aborted block.
REQ-028 After reset deassertion, the first rising edge with valid_i=1 is a legal accept.

Verification
REQ-029 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c expanded into round_key_i, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, valid_o exactly 11 cycles after accept.
REQ-030 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-031 Backpressure: ready_i=0 for 5 cycles in S_DONE -> valid_o and ciphertext_o held constant, ready_o=0; ready_i=1 -> S_IDLE next cycle.
REQ-032 Continuous valid_i=1 and ready_i=1 across two blocks (App. B then C.1) -> both ciphertexts correct; accepts 12 cycles apart.
REQ-033 rst pulsed at round 5 of App. B -> immediate ready_o=1, valid_o=0, ciphertext_o=0. A fresh App. C.1 run then completes correctly.
REQ-034 valid_i toggled during S_ROUND with changed plaintext_i -> result unaffected (still App. B ciphertext).
